// File: rtl/digit_step_counter_pkg.sv
// Shared widths, limits and direction codes for the digit step counter slice.
package digit_step_counter_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned HEX_MAX = 15;
   localparam int unsigned BCD_MAX = 9;
   localparam int unsigned PCNT_W  = 8;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // Clamp a loaded digit into the legal 0..max range.
   function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] v,
                                                    input logic [DIGIT_W-1:0] max);
      return (v > max) ? max : v;
   endfunction

endpackage

// File: rtl/digit_step_counter_prescale_tick.sv
// Prescaler: counts enabled clocks 0..PRESCALE-1 and flags the terminal edge.
module prescale_tick
   import digit_step_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PRESCALE - 1);

   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;

   // tick is decoded from pcnt_q so the counter steps on the same edge pcnt wraps
   always_comb begin
      pcnt_d = pcnt_q;
      tick   = 1'b0;
      if (clr) begin
         pcnt_d = '0;
      end else if (en) begin
         if (pcnt_q == LAST) begin
            pcnt_d = '0;
            tick   = 1'b1;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/digit_step_counter.sv
// Up/down digit counter with load, wrap or stop-at-limit, and step/carry/done strobes.
module digit_step_counter
   import digit_step_counter_pkg::*;
#(
   parameter int unsigned PRESCALE      = 5,
   parameter int unsigned MAX_COUNT     = HEX_MAX,
   parameter bit          STOP_AT_LIMIT = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               up_dn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_val,
   output logic [DIGIT_W-1:0] num,
   output logic               step,
   output logic               carry,
   output logic               done
);

   localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MAX_COUNT);

   logic               tick;
   logic [DIGIT_W-1:0] num_q, num_d;
   logic               step_q, step_d;
   logic               carry_q, carry_d;
   logic               done_q, done_d;
   logic               at_top;
   logic               at_bot;

   prescale_tick #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );

   assign at_top = (num_q == MAX_V);
   assign at_bot = (num_q == '0);

   // Priority load > tick > hold; done tracks whether num sits on the limit it points at
   always_comb begin
      num_d   = num_q;
      step_d  = 1'b0;
      carry_d = 1'b0;
      done_d  = 1'b0;
      if (load) begin
         num_d = sat_digit(load_val, MAX_V);
      end else begin
         if (tick) begin
            if (up_dn == DIR_UP) begin
               if (!at_top) begin
                  num_d  = num_q + 1'b1;
                  step_d = 1'b1;
               end else if (!STOP_AT_LIMIT) begin
                  num_d   = '0;
                  step_d  = 1'b1;
                  carry_d = 1'b1;
               end
            end else begin
               if (!at_bot) begin
                  num_d  = num_q - 1'b1;
                  step_d = 1'b1;
               end else if (!STOP_AT_LIMIT) begin
                  num_d   = MAX_V;
                  step_d  = 1'b1;
                  carry_d = 1'b1;
               end
            end
         end
         done_d = STOP_AT_LIMIT &&
                  ((up_dn == DIR_UP) ? (num_d == MAX_V) : (num_d == '0));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         num_q   <= '0;
         step_q  <= 1'b0;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         num_q   <= num_d;
         step_q  <= step_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign num   = num_q;
   assign step  = step_q;
   assign carry = carry_q;
   assign done  = done_q;

endmodule

// File: tb/tb_digit_step_counter.sv
// Directed bench: three counter configurations (hex wrap, BCD prescale-1, hex stop-at-limit).
module tb_digit_step_counter;
   import digit_step_counter_pkg::*;

   typedef struct {
      logic       en;
      logic       up;
      logic       ld;
      logic [3:0] lv;
      logic [3:0] num;
      logic       st;
      logic       ca;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, en0, up0, ld0, st0, ca0, dn0;
   logic [3:0] lv0, num0;
   logic       rst1, en1, up1, ld1, st1, ca1, dn1;
   logic [3:0] lv1, num1;
   logic       rst2, en2, up2, ld2, st2, ca2, dn2;
   logic [3:0] lv2, num2;

   int n_chk = 0;
   int n_err = 0;
   vec_t vecs[17];

   digit_step_counter u_hex (
      .clk(clk), .reset(rst0), .en(en0), .up_dn(up0), .load(ld0), .load_val(lv0),
      .num(num0), .step(st0), .carry(ca0), .done(dn0)
   );

   digit_step_counter #(.PRESCALE(1), .MAX_COUNT(BCD_MAX), .STOP_AT_LIMIT(1'b0)) u_bcd (
      .clk(clk), .reset(rst1), .en(en1), .up_dn(up1), .load(ld1), .load_val(lv1),
      .num(num1), .step(st1), .carry(ca1), .done(dn1)
   );

   digit_step_counter #(.PRESCALE(2), .MAX_COUNT(HEX_MAX), .STOP_AT_LIMIT(1'b1)) u_stop (
      .clk(clk), .reset(rst2), .en(en2), .up_dn(up2), .load(ld2), .load_val(lv2),
      .num(num2), .step(st2), .carry(ca2), .done(dn2)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      {rst0, rst1, rst2} = 3'b111;
      {en0, ld0, en1, ld1, en2, ld2} = '0;
      {up0, up1, up2} = 3'b101;
      {lv0, lv1, lv2} = '0;

      // BCD down-count table, then load saturation, wrap up, hold and load while disabled
      vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1};
      for (int i = 1; i <= 9; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'(9 - i), 1'b1, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd9, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 1'b1, 4'd14, 4'd9, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 4'd0,  4'd1, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd1, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 4'd0,  4'd2, 1'b1, 1'b0};

      #12;
      chk("rst num0", 8'(num0), 8'd0);
      chk("rst step0", 8'(st0), 8'd0);
      chk("rst carry0", 8'(ca0), 8'd0);
      chk("rst done0", 8'(dn0), 8'd0);
      chk("rst num1", 8'(num1), 8'd0);
      chk("rst num2", 8'(num2), 8'd0);
      chk("rst done2", 8'(dn2), 8'd0);

      // Free-running hex count through one full wrap
      @(negedge clk);
      rst0 = 1'b0;
      en0  = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tk(1);
         chk("t1 num", 8'(num0), 8'((k / 5) % 16));
         chk("t1 step", 8'(st0), 8'(k % 5 == 0));
         chk("t1 carry", 8'(ca0), 8'(k == 80));
      end
      chk("t1 done", 8'(dn0), 8'd0);

      // Enable dropped mid-period with pcnt=3: period resumes where it stopped
      tk(3);
      en0 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tk(1);
         chk("t5 frozen num", 8'(num0), 8'd0);
         chk("t5 frozen step", 8'(st0), 8'd0);
      end
      en0 = 1'b1;
      tk(1);
      chk("t5 resume1 num", 8'(num0), 8'd0);
      tk(1);
      chk("t5 resume2 num", 8'(num0), 8'd1);
      chk("t5 resume2 step", 8'(st0), 8'd1);

      // Load while disabled at pcnt=3 restarts the prescale period
      tk(3);
      en0 = 1'b0;
      ld0 = 1'b1;
      lv0 = 4'd12;
      tk(1);
      chk("t4 load num", 8'(num0), 8'd12);
      chk("t4 load step", 8'(st0), 8'd0);
      chk("t4 load carry", 8'(ca0), 8'd0);
      ld0 = 1'b0;
      en0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tk(1);
         chk("t4 post num", 8'(num0), (i == 5) ? 8'd13 : 8'd12);
         chk("t4 post step", 8'(st0), 8'(i == 5));
      end

      // Async reset between edges right after a step
      ld0 = 1'b1;
      lv0 = 4'd5;
      tk(1);
      chk("t6 load5", 8'(num0), 8'd5);
      ld0 = 1'b0;
      tk(5);
      chk("t6 num6", 8'(num0), 8'd6);
      chk("t6 step", 8'(st0), 8'd1);
      #2;
      rst0 = 1'b1;
      #1;
      chk("t6 async num", 8'(num0), 8'd0);
      chk("t6 async step", 8'(st0), 8'd0);
      chk("t6 async carry", 8'(ca0), 8'd0);
      chk("t6 async done", 8'(dn0), 8'd0);
      @(negedge clk);
      rst0 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tk(1);
         chk("t6 restart num", 8'(num0), (i == 5) ? 8'd1 : 8'd0);
         chk("t6 restart step", 8'(st0), 8'(i == 5));
      end

      // BCD table, PRESCALE=1
      @(negedge clk);
      rst1 = 1'b0;
      for (int i = 0; i < 17; i++) begin
         en1 = vecs[i].en;
         up1 = vecs[i].up;
         ld1 = vecs[i].ld;
         lv1 = vecs[i].lv;
         tk(1);
         chk($sformatf("t2 v%0d num", i), 8'(num1), 8'(vecs[i].num));
         chk($sformatf("t2 v%0d step", i), 8'(st1), 8'(vecs[i].st));
         chk($sformatf("t2 v%0d carry", i), 8'(ca1), 8'(vecs[i].ca));
         chk($sformatf("t2 v%0d done", i), 8'(dn1), 8'd0);
      end

      // Stop-at-limit: halt at 15, reverse, return, load clears done
      @(negedge clk);
      rst2 = 1'b0;
      en2  = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tk(1);
         chk("t3 num", 8'(num2), 8'(k / 2));
         chk("t3 step", 8'(st2), 8'(k % 2 == 0));
         chk("t3 done", 8'(dn2), 8'(k == 30));
      end
      for (int i = 0; i < 4; i++) begin
         tk(1);
         chk("t3 halt num", 8'(num2), 8'd15);
         chk("t3 halt step", 8'(st2), 8'd0);
         chk("t3 halt carry", 8'(ca2), 8'd0);
         chk("t3 halt done", 8'(dn2), 8'd1);
      end
      up2 = 1'b0;
      tk(1);
      chk("t3 rev done", 8'(dn2), 8'd0);
      chk("t3 rev num", 8'(num2), 8'd15);
      tk(1);
      chk("t3 rev2 num", 8'(num2), 8'd14);
      chk("t3 rev2 step", 8'(st2), 8'd1);
      chk("t3 rev2 done", 8'(dn2), 8'd0);
      up2 = 1'b1;
      tk(2);
      chk("t3 back num", 8'(num2), 8'd15);
      chk("t3 back done", 8'(dn2), 8'd1);
      ld2 = 1'b1;
      lv2 = 4'd15;
      tk(1);
      chk("t3 load done", 8'(dn2), 8'd0);
      chk("t3 load num", 8'(num2), 8'd15);
      ld2 = 1'b0;
      tk(1);
      chk("t3 reeval done", 8'(dn2), 8'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
